data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl.sv | 101 ++++++++++
 tb/tb_data_mem_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: word/byte stores and loads into a local RAM
// with a fixed wait-state count, holding the pipeline through Mem_stall.
module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Byte_control_MEM,
  input  logic [31:0] Addr_MEM,
  input  logic [31:0] Store_data_MEM,
  output logic [31:0] Load_data_MEM,
  output logic        Mem_stall,
  output logic        Mem_done,
  output logic        Addr_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   widx_q;
  logic [1:0]          lane_q;
  logic [31:0]         wdata_q;
  logic                byte_q, wr_q;
  logic                req, reject, accept, commit, valid;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;

  logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

  assign req    = MemRead_MEM | MemWrite_MEM;
  assign reject = (MemRead_MEM & MemWrite_MEM)
                | (~Byte_control_MEM & (|Addr_MEM[1:0]))
                | (|Addr_MEM[31:ADDR_W+2]);
  assign accept = (state == IDLE) & req & ~reject;
  assign commit = (state == BUSY) & (cnt == 4'd0);
  // Once an access is in flight the rejection checks no longer apply.
  assign valid  = (state != IDLE) | ~reject;

  // Big-endian lanes: lane 0 is the MSB byte, so shift = (3 - lane) * 8.
  assign rd_word = mem[widx_q];
  assign rd_byte = rd_word[{~lane_q, 3'b000} +: 8];

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Mem_done  = (state == DONE);
    Mem_stall = req & valid & (state != DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt           <= 4'd0;
      Load_data_MEM <= 32'd0;
      Addr_error    <= 1'b0;
    end else begin
      Addr_error <= (state == IDLE) & req & reject;
      if (accept)
        cnt <= 4'(WAIT_CYCLES);
      else if ((state == BUSY) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
      if (commit && !wr_q)
        Load_data_MEM <= byte_q ? {24'd0, rd_byte} : rd_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      widx_q  <= Addr_MEM[ADDR_W+1:2];
      lane_q  <= Addr_MEM[1:0];
      wdata_q <= Store_data_MEM;
      byte_q  <= Byte_control_MEM;
      wr_q    <= MemWrite_MEM;
    end
  end

  // A commit edge that coincides with Reset is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset && commit && wr_q) begin
      if (byte_q) mem[widx_q][{~lane_q, 3'b000} +: 8] <= wdata_q[7:0];
      else        mem[widx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a default build and a WAIT_CYCLES=0 build
// share stimulus, with a select steering the request strobes to one of them.
module tb_data_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sel = 1'b0;
  logic        rd_r = 1'b0, wr_r = 1'b0, byte_r = 1'b0;
  logic [31:0] addr_r = '0, data_r = '0;

  logic [31:0] load_a, load_b;
  logic        stall_a, stall_b, done_a, done_b, aerr_a, aerr_b;
  logic [31:0] m_load;
  logic        m_stall, m_done, m_aerr;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .MemRead_MEM(rd_r & ~sel), .MemWrite_MEM(wr_r & ~sel),
    .Byte_control_MEM(byte_r), .Addr_MEM(addr_r), .Store_data_MEM(data_r),
    .Load_data_MEM(load_a), .Mem_stall(stall_a), .Mem_done(done_a), .Addr_error(aerr_a)
  );

  data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .Clk(Clk), .Reset(Reset),
    .MemRead_MEM(rd_r & sel), .MemWrite_MEM(wr_r & sel),
    .Byte_control_MEM(byte_r), .Addr_MEM(addr_r), .Store_data_MEM(data_r),
    .Load_data_MEM(load_b), .Mem_stall(stall_b), .Mem_done(done_b), .Addr_error(aerr_b)
  );

  assign m_load  = sel ? load_b  : load_a;
  assign m_stall = sel ? stall_b : stall_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_aerr  = sel ? aerr_b  : aerr_a;

  // Applies a request at the start of cycle 0 and leaves it held through DONE;
  // returns the cycle Mem_done was seen and how many cycles stalled.
  task automatic do_access(input logic s, input logic rd, input logic wr, input logic byt,
                           input logic [31:0] a, input logic [31:0] d,
                           output int dc, output int sc);
    @(posedge Clk); #1;
    sel = s; rd_r = rd; wr_r = wr; byte_r = byt; addr_r = a; data_r = d;
    dc = -1; sc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (m_stall) sc++;
      if (m_done) begin dc = c; break; end
    end
    if (dc < 0) begin
      errors++; checks++;
      $display("FAIL access_timeout addr=%h: no Mem_done within 40 cycles", a);
    end
  endtask

  task automatic idle();
    @(posedge Clk); #1;
    rd_r = 1'b0; wr_r = 1'b0;
  endtask

  task automatic do_reject(input logic rd, input logic wr, input logic byt,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_load);
    @(posedge Clk); #1;
    sel = 1'b0; rd_r = rd; wr_r = wr; byte_r = byt; addr_r = a; data_r = d;
    @(negedge Clk);
    checks++;
    if (m_stall !== 1'b0) begin errors++; $display("FAIL reject_stall addr=%h: got %b want 0", a, m_stall); end
    @(posedge Clk); #1;
    rd_r = 1'b0; wr_r = 1'b0;
    @(negedge Clk);
    checks++;
    if (m_aerr !== 1'b1 || m_done !== 1'b0) begin
      errors++; $display("FAIL reject_pulse addr=%h: aerr=%b done=%b want 1/0", a, m_aerr, m_done);
    end
    @(negedge Clk);
    checks++;
    if (m_aerr !== 1'b0 || m_done !== 1'b0 || m_load !== exp_load) begin
      errors++;
      $display("FAIL reject_after addr=%h: aerr=%b done=%b load=%h want 0/0/%h", a, m_aerr, m_done, m_load, exp_load);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (load_a !== 32'd0 || done_a !== 1'b0 || aerr_a !== 1'b0 || stall_a !== 1'b0)
      begin errors++; $display("FAIL reset_a: load=%h done=%b aerr=%b stall=%b want 0", load_a, done_a, aerr_a, stall_a); end
    checks++;
    if (load_b !== 32'd0 || done_b !== 1'b0 || aerr_b !== 1'b0 || stall_b !== 1'b0)
      begin errors++; $display("FAIL reset_b: load=%h done=%b aerr=%b stall=%b want 0", load_b, done_b, aerr_b, stall_b); end
  endtask

  task automatic test_word();
    int dc, sc;
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0A12, dc, sc);
    checks++;
    if (dc !== 4 || sc !== 4) begin errors++; $display("FAIL sw_latency: done=%0d stall=%0d want 4/4", dc, sc); end
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, dc, sc);
    checks++;
    if (dc !== 4 || sc !== 4) begin errors++; $display("FAIL lw_latency: done=%0d stall=%0d want 4/4", dc, sc); end
    checks++;
    if (m_load !== 32'h0000_0A12) begin errors++; $display("FAIL lw_data: got %h want 00000a12", m_load); end
    idle();
    @(negedge Clk);
    checks++;
    if (m_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", m_done); end
  endtask

  task automatic test_byte_lanes();
    int dc, sc;
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h1122_3344, dc, sc);
    do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 32'hABCD_EFFF, dc, sc);
    checks++;
    if (m_load !== 32'h0000_0A12) begin errors++; $display("FAIL store_keeps_load: got %h want 00000a12", m_load); end
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h1122_FF44) begin errors++; $display("FAIL sb_lane2: got %h want 1122ff44", m_load); end
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h21, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h0000_0022 || dc !== 4) begin errors++; $display("FAIL lb_lane1: got %h cyc %0d want 00000022 cyc 4", m_load, dc); end
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h0000_0011) begin errors++; $display("FAIL lb_lane0: got %h want 00000011", m_load); end
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h23, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h0000_0044) begin errors++; $display("FAIL lb_lane3: got %h want 00000044", m_load); end
    idle();
  endtask

  task automatic test_misaligned();
    do_reject(1'b1, 1'b0, 1'b0, 32'h21, 32'h0, 32'h0000_0044);
    do_reject(1'b0, 1'b1, 1'b0, 32'h22, 32'hCAFE_0001, 32'h0000_0044);
  endtask

  task automatic test_range_conflict();
    int dc, sc;
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, dc, sc);
    idle();
    do_reject(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0055, 32'h0000_0044);
    do_reject(1'b1, 1'b1, 1'b0, 32'h20, 32'h0000_0099, 32'h0000_0044);
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h1234_5678) begin errors++; $display("FAIL range_readback: got %h want 12345678", m_load); end
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h1122_FF44) begin errors++; $display("FAIL conflict_readback: got %h want 1122ff44", m_load); end
    idle();
  endtask

  task automatic test_reset_mid_store();
    int dc, sc;
    do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0102_0304, dc, sc);
    idle();
    @(posedge Clk); #1;
    sel = 1'b0; rd_r = 1'b0; wr_r = 1'b1; byte_r = 1'b0; addr_r = 32'h40; data_r = 32'hDEAD_BEEF;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 begin Reset = 1'b0; wr_r = 1'b0; end
    @(negedge Clk);
    checks++;
    if (m_done !== 1'b0 || m_aerr !== 1'b0 || m_load !== 32'd0 || m_stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: done=%b aerr=%b load=%h stall=%b want 0/0/0/0", m_done, m_aerr, m_load, m_stall);
    end
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, dc, sc);
    checks++;
    if (m_load !== 32'h0102_0304) begin errors++; $display("FAIL abort_readback: got %h want 01020304", m_load); end
    idle();
  endtask

  task automatic test_back_to_back_w0();
    int dc, sc;
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0000_005A, dc, sc);
    checks++;
    if (dc !== 2 || sc !== 2) begin errors++; $display("FAIL w0_sb_latency: done=%0d stall=%0d want 2/2", dc, sc); end
    do_access(1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, dc, sc);
    checks++;
    if (dc !== 2 || m_load !== 32'h0000_005A) begin errors++; $display("FAIL w0_lb: cyc=%0d load=%h want 2/0000005a", dc, m_load); end
    do_access(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, dc, sc);
    checks++;
    if (dc !== 2 || m_load !== 32'h0000_005A) begin errors++; $display("FAIL w0_lw: cyc=%0d load=%h want 2/0000005a", dc, m_load); end
    idle();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_misaligned();
    test_range_conflict();
    test_reset_mid_store();
    test_back_to_back_w0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
